// File: rtl/posit_unpack_pipe.sv
// Two-stage posit operand unpacker: S1 captures |x| and the special-value flags,
// S2 splits regime/exponent/fraction into sign, scale and hidden-1 mantissa.
module posit_unpack_pipe #(
    parameter int N  = 8,
    parameter int es = 1,
    parameter int Bs = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sign,
    output logic [Bs+es:0]       out_scale,
    output logic [N-es-3:0]      out_mant,
    output logic                 out_zero,
    output logic                 out_inf,
    output logic [15:0]          out_count
);

    localparam int SW = Bs + es + 1;
    localparam int MW = N - es - 2;
    localparam int FW = N - es - 3;
    localparam int TW = es + FW;

    logic adv;

    logic         s1_valid_q, s1_valid_d;
    logic         s1_sign_q,  s1_sign_d;
    logic         s1_zero_q,  s1_zero_d;
    logic         s1_inf_q,   s1_inf_d;
    logic [N-2:0] s1_abs_q,   s1_abs_d;

    logic          out_valid_q, out_valid_d;
    logic          out_sign_q,  out_sign_d;
    logic [SW-1:0] out_scale_q, out_scale_d;
    logic [MW-1:0] out_mant_q,  out_mant_d;
    logic          out_zero_q,  out_zero_d;
    logic          out_inf_q,   out_inf_d;
    logic [15:0]   out_count_q, out_count_d;

    logic          reg_bit;
    logic          run_done;
    int            run_len;
    int            k_val;
    int            scale_val;
    logic [TW-1:0] tail_bits;
    logic [es-1:0] exp_bits;
    logic [FW-1:0] frac_bits;

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    // S1: magnitude of the operand plus zero / NaR detection
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_zero_d  = s1_zero_q;
        s1_inf_d   = s1_inf_q;
        s1_abs_d   = s1_abs_q;
        if (adv) begin
            s1_valid_d = in_valid;
            s1_sign_d  = in_data[N-1];
            s1_zero_d  = (in_data == '0);
            s1_inf_d   = (in_data == {1'b1, {(N-1){1'b0}}});
            s1_abs_d   = (N-1)'(in_data[N-1] ? (~in_data + N'(1)) : in_data);
        end
    end

    // Regime run length; a run reaching bit 0 leaves nothing after it
    always_comb begin
        reg_bit  = s1_abs_q[N-2];
        run_len  = 0;
        run_done = 1'b0;
        for (int i = N - 2; i >= 0; i--) begin
            if (!run_done && (s1_abs_q[i] == reg_bit)) begin
                run_len = run_len + 1;
            end else begin
                run_done = 1'b1;
            end
        end
        // Shift out regime and terminator; the low two bits can never hold payload
        tail_bits = TW'((s1_abs_q << (run_len + 1)) >> 2);
        exp_bits  = tail_bits[TW-1 -: es];
        frac_bits = tail_bits[FW-1:0];
        k_val     = reg_bit ? (run_len - 1) : -run_len;
        scale_val = (k_val <<< es) + int'(exp_bits);
    end

    // S2: decoded fields; specials force the numeric fields to zero
    always_comb begin
        out_valid_d = out_valid_q;
        out_sign_d  = out_sign_q;
        out_scale_d = out_scale_q;
        out_mant_d  = out_mant_q;
        out_zero_d  = out_zero_q;
        out_inf_d   = out_inf_q;
        if (adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_zero_d = s1_zero_q;
                out_inf_d  = s1_inf_q;
                if (s1_zero_q || s1_inf_q) begin
                    out_sign_d  = 1'b0;
                    out_scale_d = '0;
                    out_mant_d  = '0;
                end else begin
                    out_sign_d  = s1_sign_q;
                    out_scale_d = SW'(scale_val);
                    out_mant_d  = {1'b1, frac_bits};
                end
            end
        end
    end

    always_comb begin
        out_count_d = out_count_q;
        if (out_valid_q && out_ready) begin
            out_count_d = out_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_zero_q   <= 1'b0;
            s1_inf_q    <= 1'b0;
            s1_abs_q    <= '0;
            out_valid_q <= 1'b0;
            out_sign_q  <= 1'b0;
            out_scale_q <= '0;
            out_mant_q  <= '0;
            out_zero_q  <= 1'b0;
            out_inf_q   <= 1'b0;
            out_count_q <= 16'd0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_zero_q   <= s1_zero_d;
            s1_inf_q    <= s1_inf_d;
            s1_abs_q    <= s1_abs_d;
            out_valid_q <= out_valid_d;
            out_sign_q  <= out_sign_d;
            out_scale_q <= out_scale_d;
            out_mant_q  <= out_mant_d;
            out_zero_q  <= out_zero_d;
            out_inf_q   <= out_inf_d;
            out_count_q <= out_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sign  = out_sign_q;
    assign out_scale = out_scale_q;
    assign out_mant  = out_mant_q;
    assign out_zero  = out_zero_q;
    assign out_inf   = out_inf_q;
    assign out_count = out_count_q;

endmodule
